sound_send4: RTL and testbench

Serial byte transmitter for the sound link: on a start request it reads a run of bytes from a byte-wide playback buffer and shifts each one out on a single line as a UART-style frame (start bit, 8 data bits LSB first, stop bit). It uses the same bit timing as the sound_store4 receiver, so one block's output can drive the other's input. It sits between the playback buffer, a registered dual-port RAM with 1-cycle read latency, and the outgoing serial pin.

---
 rtl/sound_send4.sv | 180 ++++++++++++++++++
 tb/tb_sound_send4.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_send4.sv
`default_nettype none
// ============================================================================
// Module   : sound_send4
// Purpose  : Reads a run of bytes from the playback buffer and sends each one
//            as a UART-style frame (start, 8 data LSB first, stop), with bit
//            timing matching the sound_store4 receiver.
// Revision : 1.0 - initial release
// ============================================================================
module sound_send4 #(
  parameter int LENGTH = 48            // bit period is LENGTH+1 clocks, 1..63
) (
  input  logic        clock,
  input  logic        reset,           // asynchronous, active-low
  input  logic        rst,             // synchronous abort, active-high
  input  logic        start,
  input  logic [11:0] byte_count,
  output logic [10:0] rdaddress,
  input  logic [7:0]  q,
  output logic        Tx,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0]  c_LEN       = 6'(LENGTH);
  localparam logic [11:0] c_MAX_BYTES = 12'd2048;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LOAD      = 3'd2,
    S_START_BIT = 3'd3,
    S_DATA_BIT  = 3'd4,
    S_STOP_BIT  = 3'd5
  } state_t;

  state_t      r_state,     w_state;
  logic [5:0]  r_bit_len,   w_bit_len;
  logic [2:0]  r_bit_idx,   w_bit_idx;
  logic [7:0]  r_shift,     w_shift;
  logic [11:0] r_remaining, w_remaining;
  logic [10:0] r_rdaddr,    w_rdaddr;
  logic        r_tx,        w_tx;
  logic        r_busy,      w_busy;
  logic        r_done,      w_done;

  // High on the last clock of the current bit period.
  logic w_wrap;
  assign w_wrap = (r_bit_len == c_LEN);

  // State and datapath registers; reset drives the line high immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_bit_len   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_remaining <= '0;
      r_rdaddr    <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bit_len   <= w_bit_len;
      r_bit_idx   <= w_bit_idx;
      r_shift     <= w_shift;
      r_remaining <= w_remaining;
      r_rdaddr    <= w_rdaddr;
      r_tx        <= w_tx;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  // Next-state and next-output logic; the abort input overrides everything.
  always_comb begin
    w_state     = r_state;
    w_bit_len   = r_bit_len;
    w_bit_idx   = r_bit_idx;
    w_shift     = r_shift;
    w_remaining = r_remaining;
    w_rdaddr    = r_rdaddr;
    w_tx        = r_tx;
    w_busy      = r_busy;
    w_done      = 1'b0;

    if (rst) begin
      w_state     = S_IDLE;
      w_bit_len   = '0;
      w_bit_idx   = '0;
      w_shift     = '0;
      w_remaining = '0;
      w_rdaddr    = '0;
      w_tx        = 1'b1;
      w_busy      = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_tx = 1'b1;
          if (start && (byte_count != 12'd0)) begin
            w_remaining = (byte_count > c_MAX_BYTES) ? c_MAX_BYTES : byte_count;
            w_rdaddr    = '0;
            w_busy      = 1'b1;
            w_state     = S_FETCH;
          end
        end
        // Covers the one-clock read latency of the buffer.
        S_FETCH: begin
          w_state = S_LOAD;
        end
        S_LOAD: begin
          w_shift   = q;
          w_tx      = 1'b0;
          w_bit_len = '0;
          w_state   = S_START_BIT;
        end
        S_START_BIT: begin
          if (w_wrap) begin
            w_bit_len = '0;
            w_tx      = r_shift[0];
            w_bit_idx = '0;
            w_state   = S_DATA_BIT;
          end else begin
            w_bit_len = r_bit_len + 6'd1;
          end
        end
        S_DATA_BIT: begin
          if (w_wrap) begin
            w_bit_len = '0;
            if (r_bit_idx == 3'd7) begin
              w_tx    = 1'b1;
              w_state = S_STOP_BIT;
              // Prefetch the next byte so q is settled long before the stop ends.
              if (r_remaining > 12'd1) begin
                w_rdaddr = r_rdaddr + 11'd1;
              end
            end else begin
              w_shift   = {1'b0, r_shift[7:1]};
              w_tx      = r_shift[1];
              w_bit_idx = r_bit_idx + 3'd1;
            end
          end else begin
            w_bit_len = r_bit_len + 6'd1;
          end
        end
        S_STOP_BIT: begin
          if (w_wrap) begin
            w_bit_len   = '0;
            w_remaining = r_remaining - 12'd1;
            if (r_remaining != 12'd1) begin
              // Next frame follows with no idle gap.
              w_shift = q;
              w_tx    = 1'b0;
              w_state = S_START_BIT;
            end else begin
              w_done   = 1'b1;
              w_busy   = 1'b0;
              w_rdaddr = '0;
              w_state  = S_IDLE;
            end
          end else begin
            w_bit_len = r_bit_len + 6'd1;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_tx    = 1'b1;
          w_busy  = 1'b0;
        end
      endcase
    end
  end

  assign rdaddress = r_rdaddr;
  assign Tx        = r_tx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sound_send4.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_send4
// Purpose  : Self-checking bench for sound_send4 with a buffer model and a
//            frame-level reference of the expected serial waveform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_send4;

  localparam int LEN       = 48;
  localparam int BIT       = LEN + 1;
  localparam int FRAME_LEN = 10 * BIT;

  logic        clock;
  logic        reset;
  logic        rst;
  logic        start;
  logic [11:0] byte_count;
  logic [10:0] rdaddress;
  logic [7:0]  q;
  logic        Tx;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:2047];

  int n_assert = 0;
  int n_fail   = 0;

  sound_send4 #(.LENGTH(LEN)) dut (
    .clock      (clock),
    .reset      (reset),
    .rst        (rst),
    .start      (start),
    .byte_count (byte_count),
    .rdaddress  (rdaddress),
    .q          (q),
    .Tx         (Tx),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered playback buffer: one clock of read latency.
  always @(posedge clock) q <= mem[rdaddress];

  // Sends k bytes from mem[0..k-1] and checks every cycle against the frame
  // rules. If ignore_at>0, a start with byte_count=5 is pulsed at that cycle.
  task automatic send_check(input int k, input int ignore_at);
    int  total;
    int  t;
    int  f;
    int  b;
    bit  exp_tx;
    total = 2 + k * FRAME_LEN;
    start = 1'b1;
    byte_count = 12'(k);
    @(posedge clock); #1;
    start = 1'b0;
    byte_count = 12'd0;
    n_assert++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    for (int c = 1; c <= total; c++) begin
      if (c == ignore_at) begin
        start = 1'b1;
        byte_count = 12'd5;
      end
      @(posedge clock); #1;
      if (c == ignore_at) begin
        start = 1'b0;
        byte_count = 12'd0;
      end
      f = 0;
      if (c < 2 || c >= total) begin
        exp_tx = 1'b1;
      end else begin
        t = c - 2;
        f = t / FRAME_LEN;
        b = (t % FRAME_LEN) / BIT;
        if (b == 0)      exp_tx = 1'b0;
        else if (b == 9) exp_tx = 1'b1;
        else             exp_tx = mem[f][b-1];
      end
      n_assert++;
      if (Tx !== exp_tx) begin
        n_fail++;
        $display("FAIL tx cycle %0d: got %b expected %b", c, Tx, exp_tx);
      end
      n_assert++;
      if (busy !== (c < total)) begin
        n_fail++;
        $display("FAIL busy cycle %0d: got %b expected %b", c, busy, (c < total));
      end
      n_assert++;
      if (done !== (c == total)) begin
        n_fail++;
        $display("FAIL done cycle %0d: got %b expected %b", c, done, (c == total));
      end
      if (c >= 2 && c < total && ((c - 2) % FRAME_LEN) == 0) begin
        n_assert++;
        if (rdaddress !== 11'(f)) begin
          n_fail++;
          $display("FAIL rdaddr frame %0d: got %0d expected %0d", f, rdaddress, f);
        end
      end
      if (c == total) begin
        n_assert++;
        if (rdaddress !== 11'd0) begin
          n_fail++;
          $display("FAIL rdaddr end: got %0d expected 0", rdaddress);
        end
      end
    end
  endtask

  // Checks that the line stays idle for n cycles.
  task automatic check_idle(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock); #1;
      n_assert++;
      if (Tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s cycle %0d: Tx=%b busy=%b done=%b expected 1/0/0", name, c, Tx, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_assert++;
    if (Tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rdaddress !== 11'd0) begin
      n_fail++;
      $display("FAIL reset: Tx=%b busy=%b done=%b rdaddr=%0d expected 1/0/0/0", Tx, busy, done, rdaddress);
    end
    reset = 1'b1;
    check_idle("reset_hold", 5);
  endtask

  task automatic test_single_a5();
    mem[0] = 8'hA5;
    send_check(1, 0);
  endtask

  task automatic test_three_bytes();
    mem[0] = 8'h00;
    mem[1] = 8'hFF;
    mem[2] = 8'h55;
    send_check(3, 0);
  endtask

  task automatic test_zero_count();
    start = 1'b1;
    byte_count = 12'd0;
    @(posedge clock); #1;
    start = 1'b0;
    check_idle("zero_count", FRAME_LEN + 10);
  endtask

  task automatic test_restart_ignored();
    mem[0] = 8'($urandom);
    mem[1] = 8'($urandom);
    send_check(2, 300);
    check_idle("after_restart", 3);
  endtask

  // Random byte runs issued back to back, each accepted in the first IDLE cycle.
  task automatic test_back_to_back();
    int k;
    for (int r = 0; r < 3; r++) begin
      k = int'($urandom_range(1, 3));
      for (int i = 0; i < k; i++) mem[i] = 8'($urandom);
      send_check(k, 0);
    end
    check_idle("after_b2b", 3);
  endtask

  task automatic test_rst_abort();
    mem[0] = 8'($urandom);
    start = 1'b1;
    byte_count = 12'd1;
    @(posedge clock); #1;
    start = 1'b0;
    // Advance into data bit 3 (fifth bit of the frame).
    repeat (2 + 4 * BIT + 10) @(posedge clock);
    #1;
    rst = 1'b1;
    start = 1'b1;
    byte_count = 12'd1;
    @(posedge clock); #1;
    rst = 1'b0;
    start = 1'b0;
    byte_count = 12'd0;
    n_assert++;
    if (Tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rdaddress !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_abort: Tx=%b busy=%b done=%b rdaddr=%0d expected 1/0/0/0", Tx, busy, done, rdaddress);
    end
    check_idle("rst_quiet", FRAME_LEN);
    mem[0] = 8'($urandom);
    send_check(1, 0);
  endtask

  task automatic test_async_reset();
    mem[0] = 8'h3C;
    mem[1] = 8'hC3;
    start = 1'b1;
    byte_count = 12'd2;
    @(posedge clock); #1;
    start = 1'b0;
    byte_count = 12'd0;
    repeat (2 + 9 * BIT + 5) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    n_assert++;
    if (Tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: Tx=%b busy=%b expected 1/0", Tx, busy);
    end
    @(posedge clock); #3;
    reset = 1'b1;
    check_idle("after_async", 20);
  endtask

  initial begin
    reset = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    byte_count = 12'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    #2;
    test_reset();
    test_single_a5();
    test_three_bytes();
    test_zero_count();
    test_restart_ignored();
    test_back_to_back();
    test_rst_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
